pipe_rca_adder: RTL and testbench
=================================

# pipe_rca_adder

Parametrised, pipelined ripple-carry adder: the next generation of the team's 32-bit ripple-carry full adder. Adds two WIDTH-bit operands plus carry-in, splitting the carry chain into SEGMENTS registered slices so clock rate scales with width. Accepts one operation per cycle through a valid/ready handshake with per-stage backpressure. Sits in datapaths that need wide adds at full clock rate and can tolerate SEGMENTS cycles of latency.

## Interface
- WIDTH, 32: operand and sum width; must be a multiple of SEGMENTS.
- SEGMENTS, 4: number of pipeline stages / carry-chain slices; must be ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and cin valid.
- in_ready  out  1  stage 0 can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow; present only with PIPE_RCA_OVF_EN.

## Operation
- SLICE = WIDTH/SEGMENTS. Stage k (0..SEGMENTS-1) adds slice k of a and b (bits k·SLICE .. (k+1)·SLICE-1) with the carry registered by stage k-1 (stage 0 uses cin).
- Each stage register holds: valid bit, sum bits of slices 0..k, carry out of slice k, and the not-yet-added slices k+1..SEGMENTS-1 of a and b (operand skew).
- Final stage drives sum, cout, out_valid directly from registers; no combinational path from a/b/cin to outputs.
- Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. in_valid/a/b/cin may change freely while in_ready=0; no transfer occurs.
- Per-stage advance: stage k loads from stage k-1 when !valid[k] || advance[k+1]; last stage advance = !out_valid || out_ready. in_ready = advance[0]. Bubbles collapse; throughput one result per cycle when out_ready stays high.
- Outputs (sum, cout, ovf) hold stable while out_valid && !out_ready.
- Stage that loads from an invalid predecessor clears its valid bit; data bits are don't-care but must not be X after reset.
- Arithmetic: unsigned modulo 2^WIDTH; cout is the true carry of the full-width add, identical to a single-cycle ripple adder.
- Results leave in input order; no reordering, no drop.

## Timing
- Reset (rst_n low, async): all valid bits 0, all data registers 0; out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 on the first cycle after release.
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+SEGMENTS (SEGMENTS=1: next cycle).
- Full pipeline with out_ready=0: SEGMENTS operations stored, in_ready=0. Re-asserting out_ready: in_ready=1 in the same cycle (combinational through advance chain).
- Simultaneous output and input transfer on a full pipeline is legal and keeps it full.
- Reset mid-operation discards all in-flight operations; no result emitted for them.

## Configuration
- PIPE_RCA_OVF_EN defined: ovf port exists; ovf = carry into MSB XOR cout, computed in the last stage, registered with sum, same latency and hold rules.
- Undefined: no ovf port, no associated logic.

## Structure
- Package pipe_rca_pkg: default WIDTH/SEGMENTS constants and a function computing SLICE with an elaboration-time check that WIDTH % SEGMENTS == 0.
- One sub-module, rca_slice: combinational SLICE-bit ripple adder (a, b, cin -> sum, cout, carry into MSB), instantiated once per stage.

## Test plan
- Reset then a=0, b=0, cin=0 -> after SEGMENTS cycles sum=0, cout=0, out_valid one cycle with out_ready=1.
- a=1, b=2, cin=1 -> sum=4, cout=0; a=32'hFFFFFFFF, b=32'hFFFFFFFF, cin=1 -> sum=32'hFFFFFFFF, cout=1.
- a=32'h0000FFFF, b=1, cin=0 (carry across slice boundary, SEGMENTS=4) -> sum=32'h00010000, cout=0.
- Stream 16 random operations back-to-back with out_ready randomly toggling -> all 16 results match a+b+cin in order, none lost or duplicated, outputs stable while stalled.
- Fill pipeline with out_ready=0 -> in_ready=0 after SEGMENTS accepts; assert rst_n low mid-stream -> out_valid=0, sum=0 immediately, no stale results after release.
- With PIPE_RCA_OVF_EN: a=32'h7FFFFFFF, b=1, cin=0 -> sum=32'h80000000, ovf=1, cout=0; a=32'hFFFFFFFF, b=1 -> ovf=0, cout=1.

Source files
------------

// File: rtl/pipe_rca_pkg.sv
// rtl/pipe_rca_pkg.sv - shared defaults and slice sizing for pipe_rca_adder
package pipe_rca_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_SEGMENTS = 4;

    function automatic bit geometry_ok(input int width, input int segments);
        return (segments >= 1) && (width >= segments) && (width % segments == 0);
    endfunction

    function automatic int calc_slice(input int width, input int segments);
        return geometry_ok(width, segments) ? (width / segments) : 1;
    endfunction

endpackage

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational W-bit ripple-carry slice with carry-into-MSB tap
module rca_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_c_msb
);

    always_comb begin : p_ripple
        logic [W:0] v_c;
        v_c    = '0;
        v_c[0] = i_cin;
        o_sum  = '0;
        for (int i = 0; i < W; i++) begin
            o_sum[i]   = i_a[i] ^ i_b[i] ^ v_c[i];
            v_c[i + 1] = (i_a[i] & i_b[i]) | (v_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_cout  = v_c[W];
        o_c_msb = v_c[W - 1];
    end

endmodule

// File: rtl/pipe_rca_adder.sv
// rtl/pipe_rca_adder.sv - pipelined ripple-carry adder, SEGMENTS carry slices; ovf port with PIPE_RCA_OVF_EN
module pipe_rca_adder
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int SEGMENTS = DEFAULT_SEGMENTS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_RCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SLICE = calc_slice(WIDTH, SEGMENTS);

    if (!geometry_ok(WIDTH, SEGMENTS)) begin : g_bad_geometry
        $fatal(1, "pipe_rca_adder: WIDTH must be a non-zero multiple of SEGMENTS");
    end

    // Stage k inputs; operands are pre-shifted so slice k always sits at the LSBs.
    logic [WIDTH-1:0]    w_a_in   [SEGMENTS];
    logic [WIDTH-1:0]    w_b_in   [SEGMENTS];
    logic [WIDTH-1:0]    w_sum_in [SEGMENTS];
    logic [SEGMENTS-1:0] w_c_in;
    logic [SEGMENTS-1:0] w_v_in;
    logic [SEGMENTS-1:0] w_vld;
    logic [SEGMENTS-1:0] w_adv;
    logic [SEGMENTS-1:0] w_cmsb;
    logic                w_unused_cmsb;

    assign w_a_in[0]   = a;
    assign w_b_in[0]   = b;
    assign w_sum_in[0] = '0;
    assign w_c_in[0]   = cin;
    assign w_v_in[0]   = in_valid;
    assign in_ready    = w_adv[0];
    assign w_unused_cmsb = ^w_cmsb;

    for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
        logic [SLICE-1:0] w_slice_sum;
        logic             w_slice_cout;
        logic             w_slice_cmsb;
        logic             r_valid;
        logic             r_carry;
        logic [WIDTH-1:0] r_sum;

        rca_slice #(
            .W(SLICE)
        ) u_slice (
            .i_a    (w_a_in[k][SLICE-1:0]),
            .i_b    (w_b_in[k][SLICE-1:0]),
            .i_cin  (w_c_in[k]),
            .o_sum  (w_slice_sum),
            .o_cout (w_slice_cout),
            .o_c_msb(w_slice_cmsb)
        );

        // Flattened advance chain: stage k may load if any stage from k onward holds a bubble.
        assign w_adv[k]  = out_ready | ~(&w_vld[SEGMENTS-1:k]);
        assign w_vld[k]  = r_valid;
        assign w_cmsb[k] = w_slice_cmsb;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_adv[k]) begin
                r_valid <= w_v_in[k];
                r_carry <= w_slice_cout;
                r_sum   <= w_sum_in[k] | (WIDTH'(w_slice_sum) << (k * SLICE));
            end
        end

        if (k < SEGMENTS - 1) begin : g_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv[k]) begin
                    r_a <= w_a_in[k] >> SLICE;
                    r_b <= w_b_in[k] >> SLICE;
                end
            end

            assign w_a_in[k + 1]   = r_a;
            assign w_b_in[k + 1]   = r_b;
            assign w_sum_in[k + 1] = r_sum;
            assign w_c_in[k + 1]   = r_carry;
            assign w_v_in[k + 1]   = r_valid;
        end else begin : g_last
            assign sum       = r_sum;
            assign cout      = r_carry;
            assign out_valid = r_valid;
`ifdef PIPE_RCA_OVF_EN
            logic r_ovf;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv[k]) begin
                    r_ovf <= w_slice_cmsb ^ w_slice_cout;
                end
            end

            assign ovf = r_ovf;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_rca_adder.sv
// tb/tb_pipe_rca_adder.sv - self-checking bench for pipe_rca_adder against an arithmetic reference model
module tb_pipe_rca_adder;

    localparam int WIDTH    = 32;
    localparam int SEGMENTS = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             cin       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_RCA_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_rca_adder #(
        .WIDTH   (WIDTH),
        .SEGMENTS(SEGMENTS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef PIPE_RCA_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        logic [WIDTH:0] r;
        r = ref_add(x, y, c);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    task automatic drive(input logic iv, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic ordy);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick;
        tick;
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: out_valid=%b sum=%h cout=%b, expected 0/0/0", out_valid, sum, cout);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        tick;
    endtask

    task automatic test_directed;
        logic [WIDTH-1:0] va [6];
        logic [WIDTH-1:0] vb [6];
        logic             vc [6];
        int               nvec;
        logic [WIDTH:0]   exp_r;
        int               lat;
        va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000; vc[0] = 1'b0;
        va[1] = 32'h0000_0001; vb[1] = 32'h0000_0002; vc[1] = 1'b1;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF; vc[2] = 1'b1;
        va[3] = 32'h0000_FFFF; vb[3] = 32'h0000_0001; vc[3] = 1'b0;
        va[4] = 32'h7FFF_FFFF; vb[4] = 32'h0000_0001; vc[4] = 1'b0;
        va[5] = 32'hFFFF_FFFF; vb[5] = 32'h0000_0001; vc[5] = 1'b0;
`ifdef PIPE_RCA_OVF_EN
        nvec = 6;
`else
        nvec = 4;
`endif
        for (int v = 0; v < nvec; v++) begin
            exp_r = ref_add(va[v], vb[v], vc[v]);
            drive(1'b1, va[v], vb[v], vc[v], 1'b1);
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL dir%0d_in_ready: got %b, expected 1", v, in_ready);
            end
            tick;
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            lat = 0;
            for (int c = 1; c <= SEGMENTS + 4; c++) begin
                if (out_valid === 1'b1) begin
                    lat = c;
                    break;
                end
                tick;
            end
            n_cmp++;
            if (lat != SEGMENTS) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d cycles, expected %0d", v, lat, SEGMENTS);
            end
            n_cmp++;
            if ({cout, sum} !== exp_r) begin
                n_err++;
                $display("FAIL dir%0d_result: got cout=%b sum=%h, expected cout=%b sum=%h",
                         v, cout, sum, exp_r[WIDTH], exp_r[WIDTH-1:0]);
            end
`ifdef PIPE_RCA_OVF_EN
            n_cmp++;
            if (ovf !== ref_ovf(va[v], vb[v], vc[v])) begin
                n_err++;
                $display("FAIL dir%0d_ovf: got %b, expected %b", v, ovf, ref_ovf(va[v], vb[v], vc[v]));
            end
`endif
            tick;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_single_beat: out_valid=%b one cycle later, expected 0", v, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH:0]   q [$];
        logic [WIDTH:0]   exp_r;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic             ordy;
        logic             stalled;
        logic [WIDTH-1:0] h_sum;
        logic             h_cout;
`ifdef PIPE_RCA_OVF_EN
        logic             qo [$];
        logic             exp_o;
        logic             h_ovf;
        h_ovf = 1'b0;
`endif
        int sent;
        int got;
        sent    = 0;
        got     = 0;
        stalled = 1'b0;
        h_sum   = '0;
        h_cout  = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            ra   = $urandom();
            rb   = $urandom();
            rc   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            drive(sent < 16, ra, rb, rc, ordy);
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || sum !== h_sum || cout !== h_cout) begin
                    n_err++;
                    $display("FAIL b2b_hold: got v=%b cout=%b sum=%h, expected v=1 cout=%b sum=%h",
                             out_valid, cout, sum, h_cout, h_sum);
                end
`ifdef PIPE_RCA_OVF_EN
                n_cmp++;
                if (ovf !== h_ovf) begin
                    n_err++;
                    $display("FAIL b2b_hold_ovf: got %b, expected %b", ovf, h_ovf);
                end
`endif
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra: got unexpected result sum=%h, expected none", sum);
                end else begin
                    exp_r = q.pop_front();
                    if ({cout, sum} !== exp_r) begin
                        n_err++;
                        $display("FAIL b2b_result%0d: got cout=%b sum=%h, expected cout=%b sum=%h",
                                 got, cout, sum, exp_r[WIDTH], exp_r[WIDTH-1:0]);
                    end
`ifdef PIPE_RCA_OVF_EN
                    exp_o = qo.pop_front();
                    n_cmp++;
                    if (ovf !== exp_o) begin
                        n_err++;
                        $display("FAIL b2b_ovf%0d: got %b, expected %b", got, ovf, exp_o);
                    end
`endif
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(ref_add(ra, rb, rc));
`ifdef PIPE_RCA_OVF_EN
                qo.push_back(ref_ovf(ra, rb, rc));
`endif
                sent++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            h_sum   = sum;
            h_cout  = cout;
`ifdef PIPE_RCA_OVF_EN
            h_ovf   = ovf;
`endif
            tick;
        end
        n_cmp++;
        if (got != 16 || q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results with %0d outstanding, expected 16 and 0", got, q.size());
        end
    endtask

    task automatic test_full_and_reset;
        logic [WIDTH:0]   q [$];
        logic [WIDTH:0]   exp_r;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        int               accepts;
        int               lat;
        for (int c = 0; c < SEGMENTS + 2; c++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            tick;
        end
        accepts = 0;
        for (int c = 0; c < SEGMENTS + 4; c++) begin
            ra = $urandom();
            rb = $urandom();
            rc = 1'($urandom_range(0, 1));
            drive(1'b1, ra, rb, rc, 1'b0);
            if (in_ready === 1'b1) begin
                q.push_back(ref_add(ra, rb, rc));
                accepts++;
            end
            tick;
        end
        ra = $urandom();
        rb = $urandom();
        rc = 1'($urandom_range(0, 1));
        drive(1'b1, ra, rb, rc, 1'b0);
        n_cmp++;
        if (accepts != SEGMENTS || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL full_fill: accepts=%0d in_ready=%b out_valid=%b, expected %0d/0/1",
                     accepts, in_ready, out_valid, SEGMENTS);
        end
        drive(1'b1, ra, rb, rc, 1'b1);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_release_ready: got in_ready=%b, expected 1", in_ready);
        end
        exp_r = q.pop_front();
        n_cmp++;
        if ({cout, sum} !== exp_r) begin
            n_err++;
            $display("FAIL full_first_result: got cout=%b sum=%h, expected cout=%b sum=%h",
                     cout, sum, exp_r[WIDTH], exp_r[WIDTH-1:0]);
        end
        q.push_back(ref_add(ra, rb, rc));
        tick;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        exp_r = q[0];
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp_r) begin
            n_err++;
            $display("FAIL full_stays_full: v=%b rdy=%b cout=%b sum=%h, expected v=1 rdy=0 cout=%b sum=%h",
                     out_valid, in_ready, cout, sum, exp_r[WIDTH], exp_r[WIDTH-1:0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: out_valid=%b sum=%h cout=%b, expected 0/0/0", out_valid, sum, cout);
        end
        q.delete();
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < SEGMENTS + 3; c++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stale_after_reset%0d: out_valid=%b, expected 0", c, out_valid);
            end
            tick;
        end
        ra = $urandom();
        rb = $urandom();
        rc = 1'($urandom_range(0, 1));
        exp_r = ref_add(ra, rb, rc);
        drive(1'b1, ra, rb, rc, 1'b1);
        tick;
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        lat = 0;
        for (int c = 1; c <= SEGMENTS + 4; c++) begin
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
            tick;
        end
        n_cmp++;
        if (lat != SEGMENTS || {cout, sum} !== exp_r) begin
            n_err++;
            $display("FAIL post_reset_op: lat=%0d cout=%b sum=%h, expected lat=%0d cout=%b sum=%h",
                     lat, cout, sum, SEGMENTS, exp_r[WIDTH], exp_r[WIDTH-1:0]);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_full_and_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
